ysyx_23060236_btb_dm: RTL and testbench

// - Direct-mapped, ENTRIES-deep branch target buffer with per-entry 2-bit taken/not-taken counters.
// - Sits beside the IFU (next-PC prediction) and EXU (checking the predicted PC); updated from EXU branch resolution.
// - Adds a sequential flush walker, run on fence.i or satp change, that invalidates one entry per cycle.
// - Miss or not-taken prediction returns fall-through PC (addr + 4).

---
 rtl/ysyx_23060236_btb_dm.sv | 143 ++++++++++++++
 tb/tb_ysyx_23060236_btb_dm.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060236_btb_dm.sv
// Direct-mapped branch target buffer with a sequential flush walker.
// Define YSYX_23060236_BTB_2BIT_EN to enable the per-entry 2-bit taken/not-taken counters.
module ysyx_23060236_btb_dm #(
    parameter int ADDR_LEN   = 32,
    parameter int ENTRIES    = 16,
    parameter int OFFSET_LEN = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_LEN-1:0] ifu_araddr,
    output logic [ADDR_LEN-1:0] ifu_rdata,
    output logic                ifu_hit,
    input  logic [ADDR_LEN-1:0] exu_araddr,
    output logic [ADDR_LEN-1:0] exu_rdata,
    input  logic                upd_valid,
    input  logic [ADDR_LEN-1:0] upd_pc,
    input  logic [ADDR_LEN-1:0] upd_target,
    input  logic                upd_taken,
    input  logic                flush_req,
    output logic                flush_busy
);

    localparam int INDEX_LEN = $clog2(ENTRIES);
    localparam int TAG_LO    = OFFSET_LEN + INDEX_LEN;
    localparam int TAG_LEN   = ADDR_LEN - TAG_LO;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [INDEX_LEN-1:0] ptr;
    logic [INDEX_LEN-1:0] ptr_next;

    logic [ENTRIES-1:0]  valid;
    logic [TAG_LEN-1:0]  tags    [ENTRIES];
    logic [ADDR_LEN-1:0] targets [ENTRIES];
`ifdef YSYX_23060236_BTB_2BIT_EN
    logic [1:0]          ctrs    [ENTRIES];
`endif

    logic [INDEX_LEN-1:0] ifu_idx;
    logic [TAG_LEN-1:0]   ifu_tag;
    logic [INDEX_LEN-1:0] exu_idx;
    logic [TAG_LEN-1:0]   exu_tag;
    logic [INDEX_LEN-1:0] upd_idx;
    logic [TAG_LEN-1:0]   upd_tag;
    logic                 exu_hit;
    logic                 upd_hit;
    logic                 ifu_take;
    logic                 exu_take;

    assign ifu_idx = ifu_araddr[TAG_LO-1:OFFSET_LEN];
    assign ifu_tag = ifu_araddr[ADDR_LEN-1:TAG_LO];
    assign exu_idx = exu_araddr[TAG_LO-1:OFFSET_LEN];
    assign exu_tag = exu_araddr[ADDR_LEN-1:TAG_LO];
    assign upd_idx = upd_pc[TAG_LO-1:OFFSET_LEN];
    assign upd_tag = upd_pc[ADDR_LEN-1:TAG_LO];

    // Lookups are suppressed for the whole walk, not just for entries already cleared.
    assign ifu_hit = valid[ifu_idx] & (tags[ifu_idx] == ifu_tag) & ~flush_busy;
    assign exu_hit = valid[exu_idx] & (tags[exu_idx] == exu_tag) & ~flush_busy;
    assign upd_hit = valid[upd_idx] & (tags[upd_idx] == upd_tag);

`ifdef YSYX_23060236_BTB_2BIT_EN
    assign ifu_take = ifu_hit & ctrs[ifu_idx][1];
    assign exu_take = exu_hit & ctrs[exu_idx][1];
`else
    assign ifu_take = ifu_hit;
    assign exu_take = exu_hit;
`endif

    assign ifu_rdata = ifu_take ? targets[ifu_idx] : ifu_araddr + ADDR_LEN'(4);
    assign exu_rdata = exu_take ? targets[exu_idx] : exu_araddr + ADDR_LEN'(4);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        flush_busy = 1'b0;
        case (state)
            IDLE: begin
                if (flush_req) begin
                    state_next = CLEAR;
                    ptr_next   = '0;
                end
            end
            CLEAR: begin
                flush_busy = 1'b1;
                ptr_next   = ptr + INDEX_LEN'(1);
                if (ptr == INDEX_LEN'(ENTRIES - 1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= '0;
`ifdef YSYX_23060236_BTB_2BIT_EN
            for (int unsigned i = 0; i < ENTRIES; i++) ctrs[i] <= 2'b01;
`endif
        end else if (state == CLEAR) begin
            valid[ptr] <= 1'b0;
        end else if (upd_valid) begin
            if (upd_hit) begin
`ifdef YSYX_23060236_BTB_2BIT_EN
                if (upd_taken)
                    ctrs[upd_idx] <= (ctrs[upd_idx] == 2'b11) ? 2'b11 : ctrs[upd_idx] + 2'd1;
                else
                    ctrs[upd_idx] <= (ctrs[upd_idx] == 2'b00) ? 2'b00 : ctrs[upd_idx] - 2'd1;
`else
                if (!upd_taken) valid[upd_idx] <= 1'b0;
`endif
            end else if (upd_taken) begin
                valid[upd_idx] <= 1'b1;
`ifdef YSYX_23060236_BTB_2BIT_EN
                ctrs[upd_idx]  <= 2'b10;
`endif
            end
        end
    end

    // On a taken hit the tag is rewritten with its own value, so one write path covers both cases.
    always_ff @(posedge clock) begin
        if (!reset && state == IDLE && upd_valid && upd_taken) begin
            tags[upd_idx]    <= upd_tag;
            targets[upd_idx] <= upd_target;
        end
    end

endmodule

// File: tb/tb_ysyx_23060236_btb_dm.sv
// Directed self-checking bench for ysyx_23060236_btb_dm (ENTRIES=16).
// Expectations follow YSYX_23060236_BTB_2BIT_EN when defined, the counterless variant otherwise.
module tb_ysyx_23060236_btb_dm;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] ifu_araddr;
    logic [31:0] ifu_rdata;
    logic        ifu_hit;
    logic [31:0] exu_araddr;
    logic [31:0] exu_rdata;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        flush_req;
    logic        flush_busy;

    int total = 0;
    int bad   = 0;

    ysyx_23060236_btb_dm #(.ADDR_LEN(32), .ENTRIES(16), .OFFSET_LEN(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .ifu_araddr (ifu_araddr),
        .ifu_rdata  (ifu_rdata),
        .ifu_hit    (ifu_hit),
        .exu_araddr (exu_araddr),
        .exu_rdata  (exu_rdata),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_target (upd_target),
        .upd_taken  (upd_taken),
        .flush_req  (flush_req),
        .flush_busy (flush_busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        ifu_araddr = 32'h0;
        exu_araddr = 32'h0;
        upd_valid  = 1'b0;
        upd_pc     = 32'h0;
        upd_target = 32'h0;
        upd_taken  = 1'b0;
        flush_req  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_target = tgt;
        upd_taken  = taken;
        tick();
        upd_valid  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        ifu_araddr = 32'h8000_0000;
        exu_araddr = 32'h8000_0010;
        #1;
        total++; if (ifu_hit !== 1'b0) begin bad++; $display("FAIL reset_hit: got %0b want 0", ifu_hit); end
        total++; if (ifu_rdata !== 32'h8000_0004) begin bad++; $display("FAIL reset_rdata: got %h want 80000004", ifu_rdata); end
        total++; if (exu_rdata !== 32'h8000_0014) begin bad++; $display("FAIL reset_exu_rdata: got %h want 80000014", exu_rdata); end
        total++; if (flush_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", flush_busy); end
        ifu_araddr = 32'hFFFF_FFFC;
        #1;
        total++; if (ifu_rdata !== 32'h0000_0000) begin bad++; $display("FAIL reset_wrap: got %h want 00000000", ifu_rdata); end
    endtask

    // Allocation with a same-cycle read of the same index, which must see the old contents.
    task automatic test_alloc();
        upd_valid  = 1'b1;
        upd_pc     = 32'h8000_0010;
        upd_target = 32'h8000_0100;
        upd_taken  = 1'b1;
        ifu_araddr = 32'h8000_0010;
        exu_araddr = 32'h8000_0010;
        #1;
        total++; if (ifu_hit !== 1'b0) begin bad++; $display("FAIL same_cycle_hit: got %0b want 0", ifu_hit); end
        total++; if (ifu_rdata !== 32'h8000_0014) begin bad++; $display("FAIL same_cycle_rdata: got %h want 80000014", ifu_rdata); end
        tick();
        upd_valid = 1'b0;
        total++; if (ifu_hit !== 1'b1) begin bad++; $display("FAIL alloc_hit: got %0b want 1", ifu_hit); end
        total++; if (ifu_rdata !== 32'h8000_0100) begin bad++; $display("FAIL alloc_rdata: got %h want 80000100", ifu_rdata); end
        total++; if (exu_rdata !== 32'h8000_0100) begin bad++; $display("FAIL alloc_exu_rdata: got %h want 80000100", exu_rdata); end
    endtask

    task automatic test_counter();
        upd(32'h8000_0010, 32'h8000_0100, 1'b0);
`ifdef YSYX_23060236_BTB_2BIT_EN
        total++; if (ifu_hit !== 1'b1) begin bad++; $display("FAIL ctr_nt_hit: got %0b want 1", ifu_hit); end
        total++; if (ifu_rdata !== 32'h8000_0014) begin bad++; $display("FAIL ctr_nt_rdata: got %h want 80000014", ifu_rdata); end
        upd(32'h8000_0010, 32'h8000_0100, 1'b1);
        upd(32'h8000_0010, 32'h8000_0100, 1'b1);
        total++; if (ifu_rdata !== 32'h8000_0100) begin bad++; $display("FAIL ctr_tt_rdata: got %h want 80000100", ifu_rdata); end
        for (int i = 0; i < 6; i++) upd(32'h8000_0010, 32'h8000_0100, 1'b0);
        total++; if (ifu_rdata !== 32'h8000_0014) begin bad++; $display("FAIL ctr_sat0_rdata: got %h want 80000014", ifu_rdata); end
        total++; if (ifu_hit !== 1'b1) begin bad++; $display("FAIL ctr_sat0_hit: got %0b want 1", ifu_hit); end
        // Saturated at 00: one taken step reaches only 01 (still predicts not-taken).
        upd(32'h8000_0010, 32'h8000_0200, 1'b1);
        total++; if (ifu_rdata !== 32'h8000_0014) begin bad++; $display("FAIL ctr_01_rdata: got %h want 80000014", ifu_rdata); end
        upd(32'h8000_0010, 32'h8000_0200, 1'b1);
        total++; if (ifu_rdata !== 32'h8000_0200) begin bad++; $display("FAIL ctr_10_rdata: got %h want 80000200", ifu_rdata); end
`else
        total++; if (ifu_hit !== 1'b0) begin bad++; $display("FAIL nt_invalidate_hit: got %0b want 0", ifu_hit); end
        total++; if (ifu_rdata !== 32'h8000_0014) begin bad++; $display("FAIL nt_invalidate_rdata: got %h want 80000014", ifu_rdata); end
        upd(32'h8000_0010, 32'h8000_0200, 1'b0);
        total++; if (ifu_hit !== 1'b0) begin bad++; $display("FAIL miss_nt_hit: got %0b want 0", ifu_hit); end
        upd(32'h8000_0010, 32'h8000_0200, 1'b1);
        total++; if (ifu_rdata !== 32'h8000_0200) begin bad++; $display("FAIL realloc_rdata: got %h want 80000200", ifu_rdata); end
        upd(32'h8000_0010, 32'h8000_0300, 1'b1);
        total++; if (ifu_rdata !== 32'h8000_0300) begin bad++; $display("FAIL retarget_rdata: got %h want 80000300", ifu_rdata); end
`endif
    endtask

    task automatic test_alias();
        do_reset();
        upd(32'h8000_0010, 32'h8000_0100, 1'b1);
        upd(32'h8000_0050, 32'h8000_0500, 1'b1);
        ifu_araddr = 32'h8000_0010;
        #1;
        total++; if (ifu_hit !== 1'b0) begin bad++; $display("FAIL alias_old_hit: got %0b want 0", ifu_hit); end
        total++; if (ifu_rdata !== 32'h8000_0014) begin bad++; $display("FAIL alias_old_rdata: got %h want 80000014", ifu_rdata); end
        ifu_araddr = 32'h8000_0050;
        #1;
        total++; if (ifu_hit !== 1'b1) begin bad++; $display("FAIL alias_new_hit: got %0b want 1", ifu_hit); end
        total++; if (ifu_rdata !== 32'h8000_0500) begin bad++; $display("FAIL alias_new_rdata: got %h want 80000500", ifu_rdata); end
    endtask

    task automatic test_flush();
        int n;
        logic [31:0] pcs [4];
        pcs[0] = 32'h8000_0010; pcs[1] = 32'h8000_0020; pcs[2] = 32'h8000_0030; pcs[3] = 32'h8000_0040;
        do_reset();
        for (int i = 0; i < 3; i++) upd(pcs[i], pcs[i] + 32'h1000, 1'b1);
        ifu_araddr = 32'h8000_0030;
        #1;
        total++; if (ifu_hit !== 1'b1) begin bad++; $display("FAIL pre_flush_hit: got %0b want 1", ifu_hit); end
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        n = 0;
        while (flush_busy === 1'b1 && n < 40) begin
            n++;
            flush_req = (n == 3);
            upd_valid = (n == 3);
            upd_pc     = 32'h8000_0040;
            upd_target = 32'h8000_1040;
            upd_taken  = 1'b1;
            total++; if (ifu_hit !== 1'b0) begin bad++; $display("FAIL walk_hit cycle %0d: got %0b want 0", n, ifu_hit); end
            tick();
        end
        flush_req = 1'b0;
        upd_valid = 1'b0;
        total++; if (n != 16) begin bad++; $display("FAIL flush_len: got %0d want 16", n); end
        for (int i = 0; i < 4; i++) begin
            ifu_araddr = pcs[i];
            #1;
            total++; if (ifu_hit !== 1'b0 || ifu_rdata !== pcs[i] + 32'd4)
                begin bad++; $display("FAIL post_flush pc %h: got hit=%0b rdata=%h want hit=0 rdata=%h", pcs[i], ifu_hit, ifu_rdata, pcs[i] + 32'd4); end
        end
    endtask

    task automatic test_reset_mid_flush();
        int n;
        do_reset();
        upd(32'h8000_0010, 32'h8000_0100, 1'b1);
        upd(32'h8000_0020, 32'h8000_0200, 1'b1);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (flush_busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy: got %0b want 0", flush_busy); end
        ifu_araddr = 32'h8000_0010;
        exu_araddr = 32'h8000_0020;
        #1;
        total++; if (ifu_hit !== 1'b0) begin bad++; $display("FAIL mid_reset_hit: got %0b want 0", ifu_hit); end
        total++; if (exu_rdata !== 32'h8000_0024) begin bad++; $display("FAIL mid_reset_exu: got %h want 80000024", exu_rdata); end
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        n = 0;
        while (flush_busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        total++; if (n != 16) begin bad++; $display("FAIL reflush_len: got %0d want 16", n); end
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_counter();
        test_alias();
        test_flush();
        test_reset_mid_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
